// File: rtl/apb_master_pkg.sv
// apb_master_pkg: shared encodings for the APB requester and its companion slave.
//   apb_state_t     : requester FSM states (IDLE/SETUP/ACCESS)
//   apb_slv_state_t : completer-side idle/read/write encodings
//   cnt_width()     : wait-counter width for a given TIMEOUT
package apb_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    typedef enum logic [1:0] {
        SLV_IDLE  = 2'd0,
        SLV_READ  = 2'd1,
        SLV_WRITE = 2'd2
    } apb_slv_state_t;

    // Counter must be able to represent TIMEOUT-1; never narrower than 1 bit.
    function automatic int cnt_width(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// apb_wait_timer: counts ACCESS cycles spent with pready low.
//   pclk, presetn : clock, async active-low reset
//   clear         : zero the count (asserted when a command is accepted)
//   inc           : advance the count by one
//   expired       : count has reached TIMEOUT-1
module apb_wait_timer
    import apb_master_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic pclk,
    input  logic presetn,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int             CW   = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)   cnt <= '0;
        else if (clear) cnt <= '0;
        else if (inc)   cnt <= cnt + CW'(1);
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/apb_master.sv
// apb_master: APB3 requester. Turns a valid/ready command into SETUP/ACCESS
// cycles and reports completion on a one-cycle response strobe. Slave wait
// states are bounded by TIMEOUT so a stuck completer cannot hang the bus.
//   cmd_*   : command port (cmd_ready high only in IDLE)
//   rsp_*   : response, rsp_valid pulses one cycle; data/status hold until next
//   p*      : APB bus toward the completer
module apb_master
    import apb_master_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    apb_state_t state;
    logic       expired;
    logic       accept;
    logic       stall;

    assign accept = (state == IDLE) && cmd_valid;
    assign stall  = (state == ACCESS) && !pready;

    apb_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .pclk    (pclk),
        .presetn (presetn),
        .clear   (accept),
        .inc     (stall),
        .expired (expired)
    );

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state       <= IDLE;
            cmd_ready   <= 1'b1;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        paddr     <= cmd_addr;
                        pwdata    <= cmd_wdata;
                        pwrite    <= cmd_write;
                        psel      <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable <= 1'b1;
                    state   <= ACCESS;
                end
                ACCESS: begin
                    // pready is checked first so a ready on the last allowed
                    // cycle completes normally instead of timing out.
                    if (pready) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        cmd_ready   <= 1'b1;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= pslverr;
                        rsp_timeout <= 1'b0;
                        rsp_rdata   <= (!pwrite && !pslverr) ? prdata : '0;
                        state       <= IDLE;
                    end else if (expired) begin
                        psel        <= 1'b0;
                        penable     <= 1'b0;
                        cmd_ready   <= 1'b1;
                        rsp_valid   <= 1'b1;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_rdata   <= '0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    psel      <= 1'b0;
                    penable   <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
